// File: rtl/ws2812_chain_tx.sv
// WS2812/SK6812 chain serialiser: pulls colour words over valid/ready, emits them
// MSB-first as pulse-width coded bits, then holds the line low to latch the chain.
module ws2812_chain_tx #(
    parameter int CLK_HZ       = 12000000,
    parameter int BITS_PER_LED = 24,
    parameter int T0H_CYC      = 4,
    parameter int T1H_CYC      = 9,
    parameter int BIT_CYC      = 15,
    parameter int LATCH_CYC    = 3600,
    parameter int MAX_LEDS     = 1024,
    parameter int CNT_W        = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_leds,
    input  logic [BITS_PER_LED-1:0] pix_data,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic                    dout,
    output logic                    busy,
    output logic                    done,
    output logic                    underrun
);

    // An illegal parameter set never starts a frame, so the line stays low.
    localparam bit CFG_OK = (CLK_HZ > 0)
                          && ((BITS_PER_LED == 24) || (BITS_PER_LED == 32))
                          && (BIT_CYC > T1H_CYC) && (LATCH_CYC > 0)
                          && (MAX_LEDS > 0) && (MAX_LEDS < (1 << CNT_W));

    localparam int CYC_MAX = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int IDX_W   = $clog2(BITS_PER_LED);

    localparam logic [CNT_W-1:0] MAX_N     = CNT_W'(MAX_LEDS);
    localparam logic [CNT_W-1:0] ZERO_N    = {CNT_W{1'b0}};
    localparam logic [CYC_W-1:0] BIT_LAST  = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0] LATCH_END = CYC_W'(LATCH_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BITS_PER_LED - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    function automatic logic [CYC_W-1:0] high_time(input logic bit_val);
        if (bit_val) begin
            high_time = CYC_W'(T1H_CYC);
        end else begin
            high_time = CYC_W'(T0H_CYC);
        end
    endfunction

    state_t                  state_r, state_nx;
    logic [CYC_W-1:0]        cyc_r, cyc_nx;
    logic [IDX_W-1:0]        idx_r, idx_nx;
    logic [CNT_W-1:0]        rem_r, rem_nx;
    logic [BITS_PER_LED-1:0] shift_r, shift_nx;
    logic [BITS_PER_LED-1:0] buf_r, buf_nx;
    logic                    buf_full_r, buf_full_nx;
    logic                    underrun_r, underrun_nx;
    logic                    pix_ready_r, pix_ready_nx;
    logic                    dout_r, dout_nx;
    logic                    busy_r, busy_nx;
    logic                    done_r, done_nx;
    logic                    accept_s;
    logic                    boundary_s;
    logic [CNT_W-1:0]        n_s;

    // Next-state logic for the frame FSM, datapath and registered outputs.
    always_comb begin
        state_nx    = state_r;
        cyc_nx      = cyc_r;
        idx_nx      = idx_r;
        rem_nx      = rem_r;
        shift_nx    = shift_r;
        buf_nx      = buf_r;
        buf_full_nx = buf_full_r;
        underrun_nx = underrun_r;
        accept_s    = pix_valid && pix_ready_r;
        boundary_s  = (cyc_r == BIT_LAST) && (idx_r == IDX_LAST);
        n_s         = (num_leds > MAX_N) ? MAX_N : num_leds;

        case (state_r)
            ST_IDLE: begin
                if (start && CFG_OK) begin
                    underrun_nx = 1'b0;
                    cyc_nx      = {CYC_W{1'b0}};
                    idx_nx      = {IDX_W{1'b0}};
                    buf_full_nx = 1'b0;
                    rem_nx      = n_s;
                    if (n_s == ZERO_N) begin
                        state_nx = ST_LATCH;
                    end else begin
                        state_nx = ST_FETCH;
                    end
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (accept_s) begin
                    shift_nx = pix_data;
                    rem_nx   = rem_r - CNT_W'(1);
                    cyc_nx   = {CYC_W{1'b0}};
                    idx_nx   = {IDX_W{1'b0}};
                    state_nx = ST_SEND;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_SEND: begin
                if (accept_s && !boundary_s) begin
                    buf_nx      = pix_data;
                    buf_full_nx = 1'b1;
                end else begin
                    buf_nx = buf_r;
                end
                if (cyc_r == BIT_LAST) begin
                    cyc_nx = {CYC_W{1'b0}};
                    if (idx_r == IDX_LAST) begin
                        idx_nx = {IDX_W{1'b0}};
                        if (rem_r == ZERO_N) begin
                            state_nx = ST_LATCH;
                        end else if (buf_full_r) begin
                            shift_nx    = buf_r;
                            buf_full_nx = 1'b0;
                            rem_nx      = rem_r - CNT_W'(1);
                        end else if (accept_s) begin
                            // Word arriving exactly on the boundary goes straight in.
                            shift_nx = pix_data;
                            rem_nx   = rem_r - CNT_W'(1);
                        end else begin
                            underrun_nx = 1'b1;
                            state_nx    = ST_LATCH;
                        end
                    end else begin
                        idx_nx   = idx_r + IDX_W'(1);
                        shift_nx = shift_r << 1;
                    end
                end else begin
                    cyc_nx = cyc_r + CYC_W'(1);
                end
            end
            ST_LATCH: begin
                buf_full_nx = 1'b0;
                if (cyc_r == LATCH_END) begin
                    cyc_nx   = {CYC_W{1'b0}};
                    state_nx = ST_IDLE;
                end else begin
                    cyc_nx = cyc_r + CYC_W'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cyc_nx   = {CYC_W{1'b0}};
            end
        endcase

        pix_ready_nx = (state_nx == ST_FETCH)
                     || ((state_nx == ST_SEND) && (rem_nx != ZERO_N) && !buf_full_nx);
        dout_nx      = (state_nx == ST_SEND)
                     && (cyc_nx < high_time(shift_nx[BITS_PER_LED-1]));
        busy_nx      = (state_nx != ST_IDLE);
        done_nx      = (state_nx == ST_LATCH) && (cyc_nx == LATCH_END);
    end

    // State, datapath and output registers; reset drops the line at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cyc_r       <= {CYC_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            rem_r       <= {CNT_W{1'b0}};
            shift_r     <= {BITS_PER_LED{1'b0}};
            buf_r       <= {BITS_PER_LED{1'b0}};
            buf_full_r  <= 1'b0;
            underrun_r  <= 1'b0;
            pix_ready_r <= 1'b0;
            dout_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx;
            cyc_r       <= cyc_nx;
            idx_r       <= idx_nx;
            rem_r       <= rem_nx;
            shift_r     <= shift_nx;
            buf_r       <= buf_nx;
            buf_full_r  <= buf_full_nx;
            underrun_r  <= underrun_nx;
            pix_ready_r <= pix_ready_nx;
            dout_r      <= dout_nx;
            busy_r      <= busy_nx;
            done_r      <= done_nx;
        end
    end

    assign pix_ready = pix_ready_r;
    assign dout      = dout_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign underrun  = underrun_r;

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// Directed bench for ws2812_chain_tx: default 24-bit unit, a 32-bit unit and a
// fast-timing unit with a small LED limit for the clamp case.
module tb_ws2812_chain_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_start, a_valid, a_ready, a_dout, a_busy, a_done, a_under;
    logic [10:0] a_num;
    logic [23:0] a_data;
    logic        b_start, b_valid, b_ready, b_dout, b_busy, b_done, b_under;
    logic [10:0] b_num;
    logic [31:0] b_data;
    logic        c_start, c_valid, c_ready, c_dout, c_busy, c_done, c_under;
    logic [10:0] c_num;
    logic [23:0] c_data;

    logic [23:0] a_words [0:3];
    int a_cons, a_nw, a_nv, b_cons, c_cons;
    int checks   = 0;
    int failures = 0;

    ws2812_chain_tx u_a (
        .clk(clk), .reset(reset), .start(a_start), .num_leds(a_num),
        .pix_data(a_data), .pix_valid(a_valid), .pix_ready(a_ready),
        .dout(a_dout), .busy(a_busy), .done(a_done), .underrun(a_under));

    ws2812_chain_tx #(.BITS_PER_LED(32)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .num_leds(b_num),
        .pix_data(b_data), .pix_valid(b_valid), .pix_ready(b_ready),
        .dout(b_dout), .busy(b_busy), .done(b_done), .underrun(b_under));

    ws2812_chain_tx #(.T0H_CYC(1), .T1H_CYC(2), .BIT_CYC(3), .LATCH_CYC(10),
                      .MAX_LEDS(16)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .num_leds(c_num),
        .pix_data(c_data), .pix_valid(c_valid), .pix_ready(c_ready),
        .dout(c_dout), .busy(c_busy), .done(c_done), .underrun(c_under));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // One clock; the stream sources advance after every accepted word.
    task automatic tick();
        logic acc_a, acc_b, acc_c;
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
        acc_c = c_valid && c_ready;
        @(posedge clk);
        #1;
        if (acc_a) begin
            a_cons++;
            if (a_cons < a_nw) a_data = a_words[a_cons[1:0]];
            else a_data = 24'h5A5A5A;
            if (a_cons >= a_nv) a_valid = 1'b0;
        end
        if (acc_b) b_cons++;
        if (acc_c) begin
            c_cons++;
            c_data = 24'(c_cons * 7 + 1);
        end
    endtask

    // Samples one word's worth of bit cells and compares each 15-cycle cell.
    task automatic check_word(input int sel, input logic [31:0] w, input int nbits,
                              input string tag, input int poke_bit);
        for (int b = 0; b < nbits; b++) begin
            logic [14:0] obs, want;
            int th;
            th = w[nbits-1-b] ? 9 : 4;
            obs = 15'd0;
            want = 15'd0;
            for (int c = 0; c < 15; c++) begin
                want[14-c] = (c < th);
                obs[14-c] = (sel == 0) ? a_dout : b_dout;
                a_start = (b == poke_bit) && (c == 2);
                a_num = 11'd5;
                tick();
            end
            a_start = 1'b0;
            chk($sformatf("%s_bit%0d", tag, b), 32'(obs), 32'(want));
        end
    endtask

    task automatic wait_done(input int sel, input int maxc, input bit poke,
                             output int len, output int hi);
        len = 0;
        hi = 0;
        for (int i = 0; i < maxc; i++) begin
            logic d, o;
            d = (sel == 0) ? a_done : b_done;
            o = (sel == 0) ? a_dout : b_dout;
            if (d) break;
            if (o) hi++;
            len++;
            a_start = poke && (i == 100);
            a_num = 11'd5;
            tick();
        end
        a_start = 1'b0;
    endtask

    initial begin
        int len, hi, extra, bc, dc, cons_before;
        reset = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_num = 11'd0; a_data = 24'd0;
        b_start = 1'b0; b_valid = 1'b0; b_num = 11'd0; b_data = 32'd0;
        c_start = 1'b0; c_valid = 1'b0; c_num = 11'd0; c_data = 24'd1;
        a_cons = 0; a_nw = 0; a_nv = 1000; b_cons = 0; c_cons = 0;
        a_words[0] = 24'hFF0000; a_words[1] = 24'h00FF00;
        a_words[2] = 24'h0000AA; a_words[3] = 24'h000000;

        tick(); tick();
        chk("reset_a", 32'({a_ready, a_dout, a_busy, a_done, a_under}), 32'd0);
        chk("reset_b", 32'({b_ready, b_dout, b_busy, b_done, b_under}), 32'd0);
        chk("reset_c", 32'({c_ready, c_dout, c_busy, c_done, c_under}), 32'd0);
        reset = 1'b1;
        tick();

        // Three RGB LEDs with the source always valid.
        a_nw = 3; a_nv = 1000; a_cons = 0; a_data = a_words[0]; a_valid = 1'b1;
        tick();
        chk("t1_idle_ready", 32'(a_ready), 32'd0);
        chk("t1_idle_cons", 32'(a_cons), 32'd0);
        a_num = 11'd3; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("t1_fetch", 32'({a_busy, a_dout, a_ready}), 32'd5);
        tick();
        check_word(0, 32'h00FF0000, 24, "t1w0", 5);
        check_word(0, 32'h0000FF00, 24, "t1w1", -1);
        check_word(0, 32'h000000AA, 24, "t1w2", -1);
        wait_done(0, 4000, 1'b1, len, hi);
        chk("t1_latch_len", 32'(len), 32'd3600);
        chk("t1_latch_dout", 32'(hi), 32'd0);
        chk("t1_done", 32'({a_done, a_busy, a_under}), 32'd6);
        tick();
        chk("t1_after_done", 32'({a_done, a_busy, a_under}), 32'd0);
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (a_done || a_busy) extra++;
        end
        chk("t1_no_restart", 32'(extra), 32'd0);
        chk("t1_consumed", 32'(a_cons), 32'd3);

        // One RGBW LED, first and last bits set.
        b_data = 32'h80000001; b_valid = 1'b1; b_num = 11'd1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("t2_fetch", 32'({b_busy, b_ready}), 32'd3);
        tick();
        check_word(1, 32'h80000001, 32, "t2", -1);
        chk("t2_latch_entry", 32'({b_dout, b_under, b_busy}), 32'd1);
        wait_done(1, 4000, 1'b0, len, hi);
        chk("t2_latch_len", 32'(len), 32'd3600);
        chk("t2_consumed", 32'(b_cons), 32'd1);

        // Two LEDs but the second word never arrives in time.
        a_cons = 0; a_nw = 1; a_nv = 1; a_words[0] = 24'hC30F55;
        a_data = a_words[0]; a_valid = 1'b1; a_num = 11'd2; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        check_word(0, 32'h00C30F55, 24, "t3w0", -1);
        chk("t3_abort", 32'({a_under, a_dout, a_ready}), 32'd4);
        a_valid = 1'b1; a_data = 24'hFFFFFF;
        wait_done(0, 4000, 1'b0, len, hi);
        chk("t3_latch_len", 32'(len), 32'd3600);
        chk("t3_consumed", 32'(a_cons), 32'd1);
        tick();
        chk("t3_sticky", 32'({a_under, a_busy}), 32'd2);

        // Empty frame: latch only, nothing consumed.
        cons_before = a_cons;
        a_num = 11'd0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("t4_start", 32'({a_under, a_ready}), 32'd0);
        bc = 0; dc = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!a_busy) break;
            bc++;
            if (a_done) dc++;
            tick();
        end
        chk("t4_busy_len", 32'(bc), 32'd3601);
        chk("t4_done_count", 32'(dc), 32'd1);
        chk("t4_consumed", 32'(a_cons - cons_before), 32'd0);

        // Oversized request clamps to the unit's LED limit.
        c_valid = 1'b1; c_num = 11'd2047; c_start = 1'b1;
        tick();
        c_start = 1'b0;
        bc = 0; dc = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!c_busy) break;
            bc++;
            if (c_done) dc++;
            tick();
        end
        chk("t5_busy_len", 32'(bc), 32'd1164);
        chk("t5_done_count", 32'(dc), 32'd1);
        chk("t5_consumed", 32'(c_cons), 32'd16);
        chk("t5_idle", 32'({c_dout, c_under, c_ready}), 32'd0);

        // Reset in the middle of a high phase.
        a_cons = 0; a_nw = 1; a_nv = 1000; a_words[0] = 24'h800000;
        a_data = a_words[0]; a_valid = 1'b1; a_num = 11'd1; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        chk("t6_high", 32'(a_dout), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async", 32'({a_dout, a_busy, a_ready, a_done}), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("t6_idle", 32'({a_busy, a_done, a_under, a_ready, a_dout}), 32'd0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("t6_restart", 32'({a_busy, a_ready}), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
